thresholding_axilite_loader: RTL

AXI-Lite write initiator that programs a thresholding core's threshold memory from an AXI-Stream of threshold values. It sits upstream of the thresholding block's AXI-Lite slave port and converts a channel-major stream of M-bit thresholds into single-beat AXI-Lite writes. It handles addressing, handshake sequencing, completion signalling and optional response checking.

---
 rtl/thresholding_loader_pkg.sv | 7 +
 rtl/thresholding_axilite_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/thresholding_loader_pkg.sv
// thresholding_loader_pkg: loader FSM states and AXI-Lite constants
package thresholding_loader_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WRITE, RESP, DONE} state_e;
    localparam logic [1:0] AXI_OKAY = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [3:0] AXI_WSTRB = 4'hF;
endpackage

// File: rtl/thresholding_axilite_loader.sv
// thresholding_axilite_loader: turns a channel-major threshold stream into single-beat AXI-Lite writes.
// Define THRESHOLDING_LOADER_BRESP_CHECK_EN to abort the load and flag err on a non-OKAY BRESP.
module thresholding_axilite_loader
    import thresholding_loader_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 16,
    parameter int C = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [((M+7)/8)*8-1:0]     s_axis_tdata,
    output logic                       m_axilite_AWVALID,
    input  logic                       m_axilite_AWREADY,
    output logic [$clog2(C)+N-1:0]     m_axilite_AWADDR,
    output logic                       m_axilite_WVALID,
    input  logic                       m_axilite_WREADY,
    output logic [31:0]                m_axilite_WDATA,
    output logic [3:0]                 m_axilite_WSTRB,
    input  logic                       m_axilite_BVALID,
    output logic                       m_axilite_BREADY,
    input  logic [1:0]                 m_axilite_BRESP
);
    localparam int AW = $clog2(C) + N;
    localparam int CW = C > 1 ? $clog2(C) : 1;
    localparam logic [N-1:0] IDX_LAST = N'(2**N - 2);
    localparam logic [CW-1:0] CNL_LAST = CW'(C - 1);

    state_e state_q, state_d;
    logic [CW-1:0] cnl_q, cnl_d;
    logic [N-1:0] idx_q, idx_d;
    logic [M-1:0] data_q, data_d;
    logic aw_q, aw_d, w_q, w_d, err_q, err_d;
    logic bad, last_idx;
    logic unused_tdata;

    assign unused_tdata = ^s_axis_tdata;
`ifdef THRESHOLDING_LOADER_BRESP_CHECK_EN
    assign bad = m_axilite_BRESP != AXI_OKAY;
`else
    logic unused_bresp;
    assign unused_bresp = ^m_axilite_BRESP;
    assign bad = 1'b0;
`endif
    assign last_idx = idx_q == IDX_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnl_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            aw_q    <= 1'b0;
            w_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnl_q   <= cnl_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            aw_q    <= aw_d;
            w_q     <= w_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnl_d   = cnl_q;
        idx_d   = idx_q;
        data_d  = data_q;
        aw_d    = aw_q;
        w_d     = w_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH;
                cnl_d   = '0;
                idx_d   = '0;
                err_d   = 1'b0;
            end
            FETCH: if (s_axis_tvalid) begin
                data_d  = s_axis_tdata[M-1:0];
                aw_d    = 1'b1;
                w_d     = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                // address and data channels retire independently
                aw_d    = aw_q & ~m_axilite_AWREADY;
                w_d     = w_q & ~m_axilite_WREADY;
                state_d = (aw_d | w_d) ? WRITE : RESP;
            end
            RESP: if (m_axilite_BVALID) begin
                if (bad) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = last_idx ? '0 : idx_q + 1'b1;
                    cnl_d   = last_idx ? cnl_q + 1'b1 : cnl_q;
                    state_d = (last_idx && cnl_q == CNL_LAST) ? DONE : FETCH;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy              = state_q != IDLE;
    assign done              = state_q == DONE;
    assign err               = err_q;
    assign s_axis_tready     = state_q == FETCH;
    assign m_axilite_AWVALID = aw_q;
    assign m_axilite_AWADDR  = AW'({cnl_q, idx_q});
    assign m_axilite_WVALID  = w_q;
    assign m_axilite_WDATA   = 32'(data_q);
    assign m_axilite_WSTRB   = AXI_WSTRB;
    assign m_axilite_BREADY  = state_q == RESP;
endmodule
